pe_mac_seq: RTL

- Next-generation processing element: fixed-point signed dot-product engine with a parameterised local weight RAM.
- Activations stream in on a valid/ready handshake, each paired with a weight read from local RAM at base+index.
- Products are accumulated with saturation. The result leaves on a valid/ready output port with a sticky overflow flag.
- Sits between the array's activation broadcast bus and the result collector; replaces the single-operand PE.

---
 rtl/pe_pkg.sv | 26 ++
 rtl/pe_mul_pipe.sv | 43 ++++
 rtl/pe_mac_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element MAC: FSM state codes,
// saturation bounds as functions of the accumulator width, and a
// parameter legality check used at elaboration.
package pe_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Largest signed value representable in w bits (low w bits are meaningful).
  function automatic logic [127:0] sat_max(input int w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

  // Smallest signed value representable in w bits (low w bits are meaningful).
  function automatic logic [127:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

  // The accumulator must hold a full product and the multiplier needs a stage.
  function automatic bit params_ok(input int data_w, input int acc_w, input int mul_lat);
    return (acc_w >= 2 * data_w) && (mul_lat >= 1);
  endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// Pipelined signed multiplier with a matching valid shift register.
// Data registers carry no reset so the whole pipe can sit inside a DSP block;
// only the valid bits are reset.
module pe_mul_pipe #(
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  input  logic                       in_valid,
  output logic signed [2*DATA_W-1:0] prod,
  output logic [MUL_LAT-1:0]         stage_valid
);

  logic signed [2*DATA_W-1:0] prod_r [MUL_LAT];
  logic [MUL_LAT-1:0]         vld_r;

  // Track which pipeline stages hold a live product
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_r <= {MUL_LAT{1'b0}};
    end else begin
      vld_r[0] <= in_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
    end
  end

  // Multiply in the first stage, then carry the product down the pipe
  always_ff @(posedge aclk) begin
    prod_r[0] <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
    for (int i = 1; i < MUL_LAT; i++) begin
      prod_r[i] <= prod_r[i-1];
    end
  end

  assign prod        = prod_r[MUL_LAT-1];
  assign stage_valid = vld_r;

endmodule

// File: rtl/pe_mac_seq.sv
// Signed fixed-point dot-product processing element. Activations stream in
// on a valid/ready port and are paired with weights read from a local RAM
// at base+index (wrapping). Products accumulate with saturation and the
// result leaves on a valid/ready port with a sticky overflow flag.
module pe_mac_seq
  import pe_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40,
  parameter int L_RAM_SIZE = 6,
  parameter int MUL_LAT    = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  we,
  input  logic [L_RAM_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  start,
  input  logic [L_RAM_SIZE-1:0] base,
  input  logic [L_RAM_SIZE:0]   len,
  input  logic                  keep,
  input  logic [DATA_W-1:0]     ain,
  input  logic                  ain_valid,
  output logic                  ain_ready,
  output logic [ACC_W-1:0]      dout,
  output logic                  dout_ovf,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy
);

  if (!params_ok(DATA_W, ACC_W, MUL_LAT)) begin : g_bad_params
    $error("pe_mac_seq: ACC_W must be >= 2*DATA_W and MUL_LAT >= 1");
  end

  localparam int                    DEPTH   = 1 << L_RAM_SIZE;
  localparam logic [ACC_W-1:0]      ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0]      ACC_MIN = ACC_W'(sat_min(ACC_W));
  localparam logic [L_RAM_SIZE:0]   CNT_ONE = {{L_RAM_SIZE{1'b0}}, 1'b1};

  logic [DATA_W-1:0]          ram [DEPTH];

  logic [1:0]                 state_r;
  logic [L_RAM_SIZE-1:0]      base_r;
  logic [L_RAM_SIZE:0]        len_r;
  logic [L_RAM_SIZE:0]        issued_r;
  logic signed [ACC_W-1:0]    acc_r;
  logic                       ovf_r;
  logic [ACC_W-1:0]           dout_r;
  logic                       dout_ovf_r;
  logic                       dout_valid_r;

  logic signed [DATA_W-1:0]   a_q_r;
  logic signed [DATA_W-1:0]   w_q_r;
  logic                       op_valid_r;

  logic                       ready_s;
  logic                       accept_s;
  logic                       start_go_s;
  logic [L_RAM_SIZE-1:0]      rd_addr_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [MUL_LAT-1:0]         stage_valid_s;
  logic                       prod_valid_s;
  logic signed [ACC_W:0]      sum_s;
  logic signed [ACC_W-1:0]    acc_next_s;
  logic                       ovf_next_s;
  logic [MUL_LAT:0]           pending_s;
  logic                       drain_done_s;

  assign ready_s      = (state_r == S_RUN) && (issued_r < len_r);
  assign accept_s     = ain_valid && ready_s;
  assign start_go_s   = (state_r == S_IDLE) && start;
  assign rd_addr_s    = base_r + issued_r[L_RAM_SIZE-1:0];
  assign prod_valid_s = stage_valid_s[MUL_LAT-1];

  // Weight RAM write port, open in every state
  always_ff @(posedge aclk) begin
    if (we) begin
      ram[waddr] <= wdata;
    end
  end

  // Registered RAM read paired with the accepted activation (old data on collision)
  always_ff @(posedge aclk) begin
    if (accept_s) begin
      w_q_r <= ram[rd_addr_s];
      a_q_r <= ain;
    end
  end

  // Operand-pair valid feeding the multiplier
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      op_valid_r <= 1'b0;
    end else begin
      op_valid_r <= accept_s;
    end
  end

  pe_mul_pipe #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .a           (a_q_r),
    .b           (w_q_r),
    .in_valid    (op_valid_r),
    .prod        (prod_s),
    .stage_valid (stage_valid_s)
  );

  // Saturating accumulate of the product leaving the multiplier
  always_comb begin
    sum_s      = {acc_r[ACC_W-1], acc_r} + (ACC_W+1)'(prod_s);
    acc_next_s = acc_r;
    ovf_next_s = ovf_r;
    if (prod_valid_s) begin
      if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
        acc_next_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
        ovf_next_s = 1'b1;
      end else begin
        acc_next_s = sum_s[ACC_W-1:0];
      end
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Drain finishes when only the product being accumulated now is left
  always_comb begin
    pending_s          = {stage_valid_s, op_valid_r};
    pending_s[MUL_LAT] = 1'b0;
    drain_done_s       = (pending_s == {(MUL_LAT+1){1'b0}});
  end

  // Accumulator and sticky overflow
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (start_go_s) begin
      acc_r <= keep ? acc_r : {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      acc_r <= acc_next_s;
      ovf_r <= ovf_next_s;
    end
  end

  // Operation sequencing and result registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= S_IDLE;
      base_r       <= {L_RAM_SIZE{1'b0}};
      len_r        <= {(L_RAM_SIZE+1){1'b0}};
      issued_r     <= {(L_RAM_SIZE+1){1'b0}};
      dout_r       <= {ACC_W{1'b0}};
      dout_ovf_r   <= 1'b0;
      dout_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            base_r   <= base;
            len_r    <= len;
            issued_r <= {(L_RAM_SIZE+1){1'b0}};
            if (len != {(L_RAM_SIZE+1){1'b0}}) begin
              state_r <= S_RUN;
            end else begin
              state_r      <= S_DONE;
              dout_r       <= keep ? acc_r : {ACC_W{1'b0}};
              dout_ovf_r   <= 1'b0;
              dout_valid_r <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept_s) begin
            issued_r <= issued_r + CNT_ONE;
            if ((issued_r + CNT_ONE) == len_r) begin
              state_r <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_done_s) begin
            state_r      <= S_DONE;
            dout_r       <= acc_next_s;
            dout_ovf_r   <= ovf_next_s;
            dout_valid_r <= 1'b1;
          end
        end
        S_DONE: begin
          if (dout_ready) begin
            dout_valid_r <= 1'b0;
            state_r      <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign ain_ready  = ready_s;
  assign dout       = dout_r;
  assign dout_ovf   = dout_ovf_r;
  assign dout_valid = dout_valid_r;
  assign busy       = (state_r != S_IDLE);

endmodule
